// File: rtl/turn_lever_encoder_if.sv
// Lever/hazard switch inputs and sequencer request outputs
// of the turn_lever_encoder front end.
interface turn_lever_encoder_if;
    logic       LeverL;
    logic       LeverR;
    logic       Hazard;
    logic       L;
    logic       R;
    logic       Step;
    logic [1:0] Mode;

    modport master (
        output LeverL, LeverR, Hazard,
        input  L, R, Step, Mode
    );

    modport slave (
        input  LeverL, LeverR, Hazard,
        output L, R, Step, Mode
    );
endinterface

// File: rtl/turn_lever_encoder.sv
// Debounce + encode turn lever/hazard switches into Step-paced L/R requests.
// Optional lever auto-cancel after MAX_STEPS steps: define TURN_AUTO_CANCEL_EN.
module turn_lever_encoder #(
    parameter int DEB_CYCLES = 16,
    parameter int STEP_DIV   = 8,
    parameter int MAX_STEPS  = 12
) (
    input logic                 Clk,
    input logic                 Rst,
    turn_lever_encoder_if.slave bus
);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int PW = $clog2(STEP_DIV);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [PW-1:0] DIV_LAST = PW'(STEP_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEFT   = 3'd1,
        S_RIGHT  = 3'd2,
        S_HAZARD = 3'd3,
        S_CANCEL = 3'd4
    } state_t;

    logic [2:0] raw;
    logic [2:0] sync1;
    logic [2:0] sync2;
    logic [2:0] deb;

    assign raw = {bus.Hazard, bus.LeverR, bus.LeverL};

    always_ff @(posedge Clk) begin
        if (Rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Counter runs only while synced input disagrees with the accepted value.
    for (genvar i = 0; i < 3; i++) begin : g_deb
        logic [DW-1:0] cnt;
        logic          val;

        always_ff @(posedge Clk) begin
            if (Rst) begin
                cnt <= '0;
                val <= 1'b0;
            end else if (sync2[i] == val) begin
                cnt <= '0;
            end else if (cnt == DEB_LAST) begin
                cnt <= '0;
                val <= sync2[i];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign deb[i] = val;
    end

    logic [PW-1:0] pcnt;
    logic          step;

    assign step = (pcnt == DIV_LAST);

    always_ff @(posedge Clk) begin
        if (Rst)       pcnt <= '0;
        else if (step) pcnt <= '0;
        else           pcnt <= pcnt + 1'b1;
    end

    logic dl;
    logic dr;
    logic dh;
    state_t req;
    state_t req_eff;
    state_t state;
    state_t nxt;

    assign dl = deb[0];
    assign dr = deb[1];
    assign dh = deb[2];

    always_comb begin
        req = S_IDLE;
        unique case (1'b1)
            dh:              req = S_HAZARD;
            !dh && dl && dr: req = S_IDLE;
            !dh && dl && !dr: req = S_LEFT;
            !dh && !dl && dr: req = S_RIGHT;
            default:         req = S_IDLE;
        endcase
    end

`ifdef TURN_AUTO_CANCEL_EN
    localparam int SW = ($clog2(MAX_STEPS + 1) > 4) ? $clog2(MAX_STEPS + 1) : 4;
    localparam logic [SW-1:0] MAX_LAST = SW'(MAX_STEPS - 1);

    logic [SW-1:0] scnt;
    logic          lock;
    logic          lever_st;
    logic          expire;

    // A locked-out lever reads as released until both levers drop.
    assign req_eff  = (lock && (req == S_LEFT || req == S_RIGHT)) ? S_IDLE : req;
    assign lever_st = (state == S_LEFT) || (state == S_RIGHT);
    assign expire   = step && lever_st && (req_eff == state) && (scnt == MAX_LAST);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            scnt <= '0;
            lock <= 1'b0;
        end else begin
            if (step && (nxt == S_LEFT || nxt == S_RIGHT)) begin
                if (nxt != state) scnt <= '0;
                else              scnt <= scnt + 1'b1;
            end
            if (expire)        lock <= 1'b1;
            else if (!dl && !dr) lock <= 1'b0;
        end
    end
`else
    logic expire;

    assign req_eff = req;
    assign expire  = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Rst) state <= S_IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        if (step) begin
            unique case (state)
                S_IDLE:   nxt = req_eff;
                S_CANCEL: nxt = req_eff;
                S_LEFT, S_RIGHT, S_HAZARD: begin
                    if (expire)                  nxt = S_IDLE;
                    else if (req_eff == state)   nxt = state;
                    else if (req_eff == S_IDLE)  nxt = S_IDLE;
                    else                         nxt = S_CANCEL;
                end
                default:  nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.L    = 1'b0;
        bus.R    = 1'b0;
        bus.Mode = 2'd0;
        unique case (state)
            S_LEFT: begin
                bus.L    = 1'b1;
                bus.Mode = 2'd1;
            end
            S_RIGHT: begin
                bus.R    = 1'b1;
                bus.Mode = 2'd2;
            end
            S_HAZARD: begin
                bus.L    = 1'b1;
                bus.R    = 1'b1;
                bus.Mode = 2'd3;
            end
            default: ;
        endcase
    end

    assign bus.Step = step;
endmodule

// File: tb/tb_turn_lever_encoder.sv
// Scoreboard bench for turn_lever_encoder: one stimulus set per Step period,
// expected {L,R,Mode} queued at drive time and checked after the next Step.
module tb_turn_lever_encoder;
    logic Clk = 1'b0;
    logic Rst;

    turn_lever_encoder_if bus();

    turn_lever_encoder #(
        .DEB_CYCLES(4),
        .STEP_DIV  (8),
        .MAX_STEPS (3)
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .bus(bus)
    );

    always #5 Clk = ~Clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         pc    = 0;
    logic [3:0] expq[$];
    logic [3:0] cur   = 4'b0000;

    localparam logic [3:0] O_IDLE = 4'b0000;
    localparam logic [3:0] O_LEFT = 4'b1001;
    localparam logic [3:0] O_RGHT = 4'b0110;
    localparam logic [3:0] O_HAZ  = 4'b1111;

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] outs();
        return {bus.L, bus.R, bus.Mode};
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
        pc = (pc + 1) % 8;
        chk("step", {3'b000, bus.Step}, {3'b000, pc == 7});
    endtask

    // Inputs change right after a Step edge; glitch g pulses LeverR for 3 Clk.
    task automatic period(input string tag, input logic l, input logic r,
                          input logic h, input logic g, input logic [3:0] exp);
        bus.LeverL = l;
        bus.LeverR = r;
        bus.Hazard = h;
        expq.push_back(exp);
        for (int i = 0; i < 8; i++) begin
            if (g && i == 1) bus.LeverR = ~r;
            if (g && i == 4) bus.LeverR = r;
            tick();
            if (i == 3) chk({tag, "/hold"}, outs(), cur);
        end
        if (expq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: scoreboard empty, got %b", tag, outs());
        end else begin
            cur = expq.pop_front();
            chk(tag, outs(), cur);
        end
    endtask

    initial begin
        Rst        = 1'b1;
        bus.LeverL = 1'b0;
        bus.LeverR = 1'b0;
        bus.Hazard = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_out", outs(), O_IDLE);
        chk("rst_step", {3'b000, bus.Step}, 4'b0000);
        Rst = 1'b0;
        pc  = 0;

        period("idle",      0, 0, 0, 0, O_IDLE);
        period("left",      1, 0, 0, 0, O_LEFT);
        period("glitch_r",  1, 0, 0, 1, O_LEFT);
        period("l2r_cncl",  0, 1, 0, 0, O_IDLE);
        period("right",     0, 1, 0, 0, O_RGHT);
        period("hz_cncl",   0, 1, 1, 0, O_IDLE);
        period("hazard",    0, 1, 1, 0, O_HAZ);
        period("conflict",  1, 1, 0, 0, O_IDLE);
        period("release",   0, 0, 0, 0, O_IDLE);
        period("hazard2",   0, 0, 1, 0, O_HAZ);

        repeat (3) tick();
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        chk("rst_mid", outs(), O_IDLE);
        chk("rst_mid_step", {3'b000, bus.Step}, 4'b0000);
        Rst = 1'b0;
        pc  = 0;
        cur = O_IDLE;

        period("hz_post_rst", 0, 0, 1, 0, O_HAZ);
        period("idle2",       0, 0, 0, 0, O_IDLE);
`ifdef TURN_AUTO_CANCEL_EN
        period("hold1", 1, 0, 0, 0, O_LEFT);
        period("hold2", 1, 0, 0, 0, O_LEFT);
        period("hold3", 1, 0, 0, 0, O_LEFT);
        period("hold4", 1, 0, 0, 0, O_IDLE);
        period("hold5", 1, 0, 0, 0, O_IDLE);
`else
        period("hold1", 1, 0, 0, 0, O_LEFT);
        period("hold2", 1, 0, 0, 0, O_LEFT);
        period("hold3", 1, 0, 0, 0, O_LEFT);
        period("hold4", 1, 0, 0, 0, O_LEFT);
        period("hold5", 1, 0, 0, 0, O_LEFT);
`endif
        period("unhold",  0, 0, 0, 0, O_IDLE);
        period("repress", 1, 0, 0, 0, O_LEFT);
        period("hz_left", 1, 0, 1, 0, O_IDLE);
        period("hz_ok",   1, 0, 1, 0, O_HAZ);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
